// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command/response sequencer.
// Holds the FSM state encoding, byte/retry widths and a counter-width helper.
package uart_cmd_ctrl_pkg;

  localparam int BYTE_W               = 8;
  localparam int RETRY_W              = 2;
  localparam int DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_WAIT_TX = 2'd2,
    ST_WAIT_RX = 2'd3
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int ctr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Bundle of host-side and UART-side handshake signals around uart_cmd_ctrl.
// The slave modport is the sequencer's view; master is everything around it.
interface uart_cmd_ctrl_if;
  import uart_cmd_ctrl_pkg::*;

  logic              i_Start;
  logic [BYTE_W-1:0] i_Cmd_Byte;
  logic              i_Abort;
  logic              i_Tx_Active;
  logic              i_Tx_Done;
  logic              i_Rx_DV;
  logic [BYTE_W-1:0] i_Rx_Byte;

  logic               o_Tx_DV;
  logic [BYTE_W-1:0]  o_Tx_Byte;
  logic               o_Busy;
  logic               o_Done;
  logic               o_Timeout;
  logic [BYTE_W-1:0]  o_Resp_Byte;
  logic [RETRY_W-1:0] o_Retries;

  modport slave (
    input  i_Start, i_Cmd_Byte, i_Abort, i_Tx_Active, i_Tx_Done, i_Rx_DV, i_Rx_Byte,
    output o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Timeout, o_Resp_Byte, o_Retries
  );

  modport master (
    output i_Start, i_Cmd_Byte, i_Abort, i_Tx_Active, i_Tx_Done, i_Rx_DV, i_Rx_Byte,
    input  o_Tx_DV, o_Tx_Byte, o_Busy, o_Done, o_Timeout, o_Resp_Byte, o_Retries
  );

endinterface

// File: rtl/uart_cmd_ctrl_timeout_ctr.sv
// Response timeout counter: synchronous clear, count enable, terminal-count flag.
// Saturates at TIMEOUT_CLKS-1 so it can never wrap while enabled.
module uart_cmd_ctrl_timeout_ctr
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 4000
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  localparam int               CNT_W = ctr_width(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last    = (r_count == LAST);
  assign o_Expired = w_last;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_count <= '0;
    end else if (i_Clear) begin
      r_count <= '0;
    end else if (i_Enable && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command/response sequencer: sends one byte through uart_tx, waits for one
// reply byte from uart_rx under a timeout, and resends up to MAX_RETRIES times.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  // Roughly 46 bit-times of silence; 4000 clocks at the default bit rate.
  parameter int TIMEOUT_CLKS = 46 * CLKS_PER_BIT - 2,
  parameter int MAX_RETRIES  = 2
) (
  input  logic            i_Clock,
  input  logic            i_Rst_n,
  uart_cmd_ctrl_if.slave  bus
);

  state_t             r_state,     w_state_nxt;
  logic               r_tx_dv,     w_tx_dv_nxt;
  logic [BYTE_W-1:0]  r_tx_byte,   w_tx_byte_nxt;
  logic               r_done,      w_done_nxt;
  logic               r_timeout,   w_timeout_nxt;
  logic [BYTE_W-1:0]  r_resp_byte, w_resp_byte_nxt;
  logic [RETRY_W-1:0] r_retries,   w_retries_nxt;

  logic w_in_wait_rx;
  logic w_expired;

  assign w_in_wait_rx = (r_state == ST_WAIT_RX);

  // Timer runs only in WAIT_RX and is held clear in every other state.
  uart_cmd_ctrl_timeout_ctr #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout_ctr (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .i_Clear   (!w_in_wait_rx),
    .i_Enable  (w_in_wait_rx),
    .o_Expired (w_expired)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state     <= ST_IDLE;
      r_tx_dv     <= 1'b0;
      r_tx_byte   <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_resp_byte <= '0;
      r_retries   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_tx_dv     <= w_tx_dv_nxt;
      r_tx_byte   <= w_tx_byte_nxt;
      r_done      <= w_done_nxt;
      r_timeout   <= w_timeout_nxt;
      r_resp_byte <= w_resp_byte_nxt;
      r_retries   <= w_retries_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_tx_dv_nxt     = 1'b0;
    w_tx_byte_nxt   = r_tx_byte;
    w_done_nxt      = 1'b0;
    w_timeout_nxt   = 1'b0;
    w_resp_byte_nxt = r_resp_byte;
    w_retries_nxt   = r_retries;

    // Abort overrides everything, including a start seen in IDLE.
    if (bus.i_Abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.i_Start) begin
            w_tx_byte_nxt = bus.i_Cmd_Byte;
            w_retries_nxt = '0;
            w_state_nxt   = ST_SEND;
          end
        end

        ST_SEND: begin
          // A frame left over from an aborted run must finish on the line first.
          if (!bus.i_Tx_Active) begin
            w_tx_dv_nxt = 1'b1;
            w_state_nxt = ST_WAIT_TX;
          end
        end

        ST_WAIT_TX: begin
          if (bus.i_Tx_Done) begin
            w_state_nxt = ST_WAIT_RX;
          end
        end

        ST_WAIT_RX: begin
          // A reply arriving on the expiry edge still counts as a reply.
          if (bus.i_Rx_DV) begin
            w_resp_byte_nxt = bus.i_Rx_Byte;
            w_done_nxt      = 1'b1;
            w_state_nxt     = ST_IDLE;
          end else if (w_expired) begin
            if (r_retries < RETRY_W'(MAX_RETRIES)) begin
              w_retries_nxt = r_retries + 1'b1;
              w_state_nxt   = ST_SEND;
            end else begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = ST_IDLE;
            end
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_Tx_DV     = r_tx_dv;
  assign bus.o_Tx_Byte   = r_tx_byte;
  assign bus.o_Busy      = (r_state != ST_IDLE);
  assign bus.o_Done      = r_done;
  assign bus.o_Timeout   = r_timeout;
  assign bus.o_Resp_Byte = r_resp_byte;
  assign bus.o_Retries   = r_retries;

endmodule
